// File: rtl/sdes_pkg.sv
// sdes_pkg: S-DES key widths, P10/P8 tables, key-schedule state enum and permutation helpers.
package sdes_pkg;
   localparam int KEY_W    = 10;
   localparam int SUBKEY_W = 8;
   localparam int HALF_W   = 5;
   localparam int P10_TAB [KEY_W]    = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8_TAB  [SUBKEY_W] = '{6, 3, 7, 4, 8, 5, 10, 9};
   typedef enum logic [2:0] {
      S_IDLE, S_P10, S_SHIFT1, S_GEN_K1, S_SHIFT2, S_GEN_K2, S_DONE
   } sdes_ks_state_t;
   // Table entries are 1-based S-DES positions with position 1 at the MSB.
   function automatic logic [KEY_W-1:0] p10(input logic [KEY_W-1:0] w);
      logic [KEY_W-1:0] r;
      for (int i = 0; i < KEY_W; i++) r[KEY_W-1-i] = w[KEY_W-P10_TAB[i]];
      return r;
   endfunction
   function automatic logic [SUBKEY_W-1:0] p8(input logic [KEY_W-1:0] w);
      logic [SUBKEY_W-1:0] r;
      for (int i = 0; i < SUBKEY_W; i++) r[SUBKEY_W-1-i] = w[KEY_W-P8_TAB[i]];
      return r;
   endfunction
endpackage

// File: rtl/sdes_rotate_halves.sv
// sdes_rotate_halves: left-rotates each 5-bit half of a 10-bit word by SHIFT.
module sdes_rotate_halves
   import sdes_pkg::*;
#(
   parameter int SHIFT = 1
) (
   input  logic [KEY_W-1:0] i_word,
   output logic [KEY_W-1:0] o_word
);
   logic [HALF_W-1:0] hi, lo;
   assign hi = i_word[KEY_W-1:HALF_W];
   assign lo = i_word[HALF_W-1:0];
   assign o_word = {hi[HALF_W-1-SHIFT:0], hi[HALF_W-1:HALF_W-SHIFT],
                    lo[HALF_W-1-SHIFT:0], lo[HALF_W-1:HALF_W-SHIFT]};
endmodule

// File: rtl/sdes_key_schedule.sv
// sdes_key_schedule: sequential S-DES K1/K2 generator with valid/ready on both sides.
// SDES_KEYSCHED_DECRYPT_EN adds i_decrypt, which swaps K1/K2 for decryption.
module sdes_key_schedule
   import sdes_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [KEY_W-1:0]    i_key,
   input  logic                i_key_valid,
   output logic                o_key_ready,
   output logic [SUBKEY_W-1:0] o_key1,
   output logic [SUBKEY_W-1:0] o_key2,
   output logic                o_keys_valid,
   input  logic                i_keys_ready,
`ifdef SDES_KEYSCHED_DECRYPT_EN
   input  logic                i_decrypt,
`endif
   output logic [7:0]          o_sched_count
);
   sdes_ks_state_t      state_q, state_d;
   logic [KEY_W-1:0]    work_q, work_d, rot1, rot2;
   logic [SUBKEY_W-1:0] k1_q, k1_d, key1_q, key1_d, key2_q, key2_d;
   logic                valid_q, valid_d, swap;
   logic [7:0]          cnt_q, cnt_d;

   sdes_rotate_halves #(.SHIFT(1)) u_rot1 (.i_word(work_q), .o_word(rot1));
   sdes_rotate_halves #(.SHIFT(2)) u_rot2 (.i_word(work_q), .o_word(rot2));

`ifdef SDES_KEYSCHED_DECRYPT_EN
   logic dec_q, dec_d;
   assign dec_d = (state_q == S_IDLE && i_key_valid) ? i_decrypt : dec_q;
   assign swap  = dec_q;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) dec_q <= 1'b0;
      else          dec_q <= dec_d;
`else
   assign swap = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      k1_d    = k1_q;
      key1_d  = key1_q;
      key2_d  = key2_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:   if (i_key_valid) begin
                      work_d  = i_key;
                      state_d = S_P10;
                   end
         S_P10:    begin work_d = p10(work_q); state_d = S_SHIFT1; end
         S_SHIFT1: begin work_d = rot1; state_d = S_GEN_K1; end
         S_GEN_K1: begin k1_d = p8(work_q); state_d = S_SHIFT2; end
         S_SHIFT2: begin work_d = rot2; state_d = S_GEN_K2; end
         S_GEN_K2: begin
                      key1_d  = swap ? p8(work_q) : k1_q;
                      key2_d  = swap ? k1_q : p8(work_q);
                      valid_d = 1'b1;
                      state_d = S_DONE;
                   end
         S_DONE:   if (i_keys_ready) begin
                      valid_d = 1'b0;
                      cnt_d   = cnt_q + 8'd1;
                      state_d = S_IDLE;
                   end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         k1_q    <= '0;
         key1_q  <= '0;
         key2_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         k1_q    <= k1_d;
         key1_q  <= key1_d;
         key2_q  <= key2_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end

   assign o_key_ready   = (state_q == S_IDLE);
   assign o_key1        = key1_q;
   assign o_key2        = key2_q;
   assign o_keys_valid  = valid_q;
   assign o_sched_count = cnt_q;
endmodule

// File: tb/tb_sdes_key_schedule.sv
// tb_sdes_key_schedule: random + directed bench against a transaction-level S-DES key model.
module tb_sdes_key_schedule;
   logic       i_clk = 1'b0, i_rst_n = 1'b0;
   logic [9:0] i_key = '0;
   logic       i_key_valid = 1'b0, i_keys_ready = 1'b0, dec_in;
   logic       o_key_ready, o_keys_valid;
   logic [7:0] o_key1, o_key2, o_sched_count;
`ifdef SDES_KEYSCHED_DECRYPT_EN
   logic i_decrypt = 1'b0;
   assign dec_in = i_decrypt;
`else
   assign dec_in = 1'b0;
`endif

   sdes_key_schedule dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key(i_key), .i_key_valid(i_key_valid),
      .o_key_ready(o_key_ready), .o_key1(o_key1), .o_key2(o_key2),
      .o_keys_valid(o_keys_valid), .i_keys_ready(i_keys_ready),
`ifdef SDES_KEYSCHED_DECRYPT_EN
      .i_decrypt(i_decrypt),
`endif
      .o_sched_count(o_sched_count)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0, errors = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, a, e);
      end
   endtask

   localparam int T10 [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int T8  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};

   function automatic int rot5(input int h, input int s);
      return ((h << s) | (h >> (5 - s))) & 31;
   endfunction

   function automatic logic [7:0] pick8(input int w);
      int r = 0;
      for (int i = 0; i < 8; i++) r = r * 2 + ((w >> (10 - T8[i])) & 1);
      return 8'(r);
   endfunction

   // Returns {K1, K2} computed from the master key by position tables.
   function automatic logic [15:0] ref_keys(input logic [9:0] k);
      int b [11];
      int q [11];
      int l = 0, r = 0;
      logic [7:0] k1, k2;
      for (int i = 1; i <= 10; i++) b[i] = int'(k[10-i]);
      for (int i = 1; i <= 10; i++) q[i] = b[T10[i-1]];
      for (int i = 1; i <= 5; i++) begin
         l = l * 2 + q[i];
         r = r * 2 + q[i+5];
      end
      l = rot5(l, 1); r = rot5(r, 1);
      k1 = pick8(l * 32 + r);
      l = rot5(l, 2); r = rot5(r, 2);
      k2 = pick8(l * 32 + r);
      return {k1, k2};
   endfunction

   // Model: m_age counts cycles since key acceptance (0 = waiting for a key, 6 = presenting).
   int         m_age = 0, m_hs = 0;
   logic [15:0] m_p = '0;
   logic        m_dec = 1'b0, m_valid = 1'b0;
   logic [7:0]  m_k1 = '0, m_k2 = '0, m_cnt = '0;
   always @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         m_age <= 0; m_p <= '0; m_dec <= 1'b0; m_valid <= 1'b0;
         m_k1 <= '0; m_k2 <= '0; m_cnt <= '0;
      end else if (m_age == 0) begin
         if (i_key_valid) begin
            m_p <= ref_keys(i_key); m_dec <= dec_in; m_age <= 1;
         end
      end else if (m_age < 5) m_age <= m_age + 1;
      else if (m_age == 5) begin
         m_age <= 6; m_valid <= 1'b1;
         m_k1 <= m_dec ? m_p[7:0] : m_p[15:8];
         m_k2 <= m_dec ? m_p[15:8] : m_p[7:0];
      end else if (i_keys_ready) begin
         m_valid <= 1'b0; m_cnt <= m_cnt + 8'd1; m_hs <= m_hs + 1; m_age <= 0;
      end

   logic [7:0] prev_cnt = '0;
   logic       seen_wrap = 1'b0;
   always @(negedge i_clk) begin
      chk("ready", o_key_ready, m_age == 0);
      chk("valid", o_keys_valid, m_valid);
      chk("key1", o_key1, m_k1);
      chk("key2", o_key2, m_k2);
      chk("count", o_sched_count, m_cnt);
      if (prev_cnt == 8'hFF && o_sched_count == 8'h00) seen_wrap <= 1'b1;
      prev_cnt <= o_sched_count;
   end

   task automatic wait_valid(input string n);
      int c = 0;
      while (!o_keys_valid && c < 50) begin
         @(negedge i_clk);
         c++;
      end
      chk({n, "_timeout"}, o_keys_valid, 1'b1);
   endtask

   task automatic send(input logic [9:0] k);
      @(negedge i_clk);
      i_key = k; i_key_valid = 1'b1;
      @(negedge i_clk);
      i_key_valid = 1'b0;
   endtask

   logic [7:0] h1, h2, hc;
   int         cyc, hs0;
   initial begin
      chk("ref_ex", ref_keys(10'b1010000010), 16'hA443);
      chk("ref_zero", ref_keys(10'h000), 16'h0000);
      chk("ref_ones", ref_keys(10'h3FF), 16'hFFFF);
      repeat (2) @(negedge i_clk);
      chk("rst_key1", o_key1, 8'h00);
      chk("rst_valid", o_keys_valid, 1'b0);
      chk("rst_ready", o_key_ready, 1'b1);
      i_rst_n = 1'b1;
      i_keys_ready = 1'b1;
      send(10'b1010000010);
      wait_valid("ex");
      chk("ex_key1", o_key1, 8'hA4);
      chk("ex_key2", o_key2, 8'h43);
      @(negedge i_clk);
      chk("ex_count", o_sched_count, 8'd1);
      @(negedge i_clk);
      i_key = 10'h000; i_key_valid = 1'b1;
      @(negedge i_clk);
      i_key = 10'h3FF;
      wait_valid("b2b0");
      chk("b2b0_key1", o_key1, 8'h00);
      @(negedge i_clk);
      chk("b2b_ready", o_key_ready, 1'b1);
      @(negedge i_clk);
      chk("b2b_accept", o_key_ready, 1'b0);
      i_key_valid = 1'b0;
      wait_valid("b2b1");
      chk("b2b1_key1", o_key1, 8'hFF);
      chk("b2b1_key2", o_key2, 8'hFF);
      @(negedge i_clk);
      i_keys_ready = 1'b0;
      send(10'($urandom));
      wait_valid("stall");
      h1 = o_key1; h2 = o_key2; hc = o_sched_count;
      repeat (20) begin
         @(negedge i_clk);
         i_key_valid = 1'($urandom); i_key = 10'($urandom);
         chk("stall_key1", o_key1, h1);
         chk("stall_key2", o_key2, h2);
         chk("stall_cnt", o_sched_count, hc);
         chk("stall_ready", o_key_ready, 1'b0);
      end
      i_key_valid = 1'b0; i_keys_ready = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_key = 10'h155; i_key_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_key_valid = 1'b0;
      @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("arst_key1", o_key1, 8'h00);
      chk("arst_key2", o_key2, 8'h00);
      chk("arst_valid", o_keys_valid, 1'b0);
      chk("arst_count", o_sched_count, 8'h00);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      send(10'b1010000010);
      wait_valid("post_rst");
      chk("post_rst_key1", o_key1, 8'hA4);
      chk("post_rst_key2", o_key2, 8'h43);
      hs0 = m_hs; cyc = 0;
      while (m_hs < hs0 + 260 && cyc < 20000) begin
         @(negedge i_clk);
         i_key = 10'($urandom); i_key_valid = 1'($urandom);
         i_keys_ready = ($urandom_range(3) != 0);
`ifdef SDES_KEYSCHED_DECRYPT_EN
         i_decrypt = 1'($urandom);
`endif
         cyc++;
      end
      chk("rand_budget", m_hs >= hs0 + 260, 1'b1);
      @(negedge i_clk);
      chk("count_wrap", seen_wrap, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
